display_mux_ctrl: RTL and testbench
===================================

Name: display_mux_ctrl

Overview:
Arbiter/scheduler that shares the 8-digit seven-segment display driver among several requesters, such as a counter, a debug register view or an error code.
- Selects one requester at a time with round-robin and a minimum dwell time, and optionally rotates between active requesters.
- Applies per-source blinking.
- Drives the display driver's 32-bit data and enable inputs directly.

Parameters:
N_SRC, 4, number of requesters (2..8)
DWELL_CYCLES, 100000000, minimum display time per grant (1 s at 100 MHz)
BLINK_HALF, 25000000, blink half-period in cycles (2 Hz blink)

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  reset; asynchronous, active-low
req  in  N_SRC  request per source, level-held while source wants display
src_data  in  32*N_SRC  packed 8-hex-digit words; source i at [32*i+31:32*i]
blink  in  N_SRC  per-source blink enable, applies while that source is granted
auto_rotate  in  1  1 = rotate among requesters after dwell; 0 = hold grant until req drops
disp_data  out  32  word to display driver
disp_enable  out  1  display driver enable
grant  out  N_SRC  one-hot grant, all-zero when idle
active_id  out  $clog2(N_SRC)  index of granted source, valid when grant != 0

Behaviour:
- Reset (rst_n=0, asynchronous), all outputs registered:
  - grant=0, active_id=0, disp_data=0, disp_enable=0.
  - State=IDLE, dwell and blink counters=0.
  - Round-robin pointer=N_SRC-1, so source 0 wins first.
- FSM states: IDLE, SHOW.
- IDLE:
  - Outputs as reset.
  - If req != 0 at a rising edge: next cycle grant the first set req bit searching upward from pointer+1 (mod N_SRC), enter SHOW.
- Grant selection:
  - Pointer updates to the granted index on every grant.
  - Dwell counter and blink counter clear to 0 on every new grant.
  - Grant latency is 1 cycle from req sampled.
- SHOW:
  - disp_data = src_data of the granted source, registered (1-cycle latency); updated every cycle while granted.
  - Dwell counter increments each cycle and saturates at DWELL_CYCLES-1; "dwell_done" = counter at saturation.
- Release rules, evaluated each cycle in SHOW in priority order:
  1. req[granted]=0 (early release allowed, dwell ignored):
     - If another req is set, grant the next via round-robin on the next cycle with no idle gap.
     - Otherwise go to IDLE on the next cycle (grant=0, disp_enable=0).
  2. auto_rotate=1, dwell_done, and another req bit is set: move to the next requester via round-robin on the next cycle.
  3. Otherwise hold the grant. A lone requester is held indefinitely.
- disp_enable in SHOW:
  - If blink[granted]=0: 1.
  - If blink[granted]=1: the blink counter counts 0..BLINK_HALF-1 and wraps; disp_enable toggles on each wrap.
  - disp_enable starts at 1 on the cycle the grant appears.
  - Deasserting blink mid-grant forces disp_enable=1 on the next cycle; the blink counter keeps running.
- Simultaneous events:
  - New requests arriving during SHOW never preempt before dwell_done, except by the release of the current owner.
  - req changes in the same cycle as a switch are resolved using the sampled req vector of that edge.
- Invariants:
  - grant is always zero or one-hot.
  - active_id matches grant.
  - Changing auto_rotate mid-grant takes effect the next cycle; the dwell counter is not cleared.
- Reset mid-SHOW: immediate return to reset values; the first grant after reset restarts at source 0.

Test Plan (bench overrides N_SRC=4, DWELL_CYCLES=8, BLINK_HALF=3):
- Reset then req=4'b0000 for 20 cycles -> grant=0, disp_enable=0, disp_data=0 throughout.
- req=4'b0110, src_data[1]=32'h12345678, auto_rotate=1 -> 1 cycle later grant=4'b0010, active_id=1, disp_data=32'h12345678, disp_enable=1. After 8 cycles of SHOW, grant=4'b0100; 8 cycles later grant=4'b0010 again.
- auto_rotate=0, req=4'b1001 -> grant=4'b0001 held for 50 cycles. Drop req[0] -> next cycle grant=4'b1000 with no cycle of grant=0. Drop req[3] -> next cycle IDLE, disp_enable=0.
- Source 2 granted, req[2] dropped at dwell count 3 with no other req -> IDLE next cycle, so early release ignores dwell. Reassert req=4'b0001 -> grant=4'b0001, pointer order resumes after index 2.
- blink[0]=1 with source 0 granted -> disp_enable pattern 1,1,1,0,0,0,1,... from the grant cycle. Clear blink[0] during a 0 phase -> disp_enable=1 next cycle.
- Assert rst_n=0 mid-SHOW with grant=4'b0100 -> outputs zero asynchronously. Release with req=4'b0101 -> first grant=4'b0001.

Source files
------------

// File: rtl/display_mux_ctrl.sv
// display_mux_ctrl: round-robin owner of the 8-digit display driver
// with a minimum dwell per grant and per-source blinking.
module display_mux_ctrl #(
   parameter int N_SRC        = 4,
   parameter int DWELL_CYCLES = 100000000,
   parameter int BLINK_HALF   = 25000000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_SRC-1:0]         req,
   input  logic [32*N_SRC-1:0]      src_data,
   input  logic [N_SRC-1:0]         blink,
   input  logic                     auto_rotate,
   output logic [31:0]              disp_data,
   output logic                     disp_enable,
   output logic [N_SRC-1:0]         grant,
   output logic [$clog2(N_SRC)-1:0] active_id
);
   localparam int IW = $clog2(N_SRC);
   localparam int DW = $clog2(DWELL_CYCLES + 1);
   localparam int BW = $clog2(BLINK_HALF + 1);
   localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);
   localparam logic [IW-1:0] PTR_RST = IW'(N_SRC - 1);
   localparam logic [N_SRC-1:0] ONE = {{(N_SRC-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE, SHOW} state_t;

   state_t           state, state_n;
   logic [IW-1:0]    ptr, ptr_n;
   logic [IW-1:0]    id_n, pick;
   logic [DW-1:0]    dwell, dwell_n;
   logic [BW-1:0]    bcnt, bcnt_n;
   logic [N_SRC-1:0] grant_n, others, pool;
   logic [31:0]      data_n;
   logic             en_n, take, hold, dwell_done, wrap;

   // first set bit of v searching upward from p+1, wrapping
   function automatic logic [IW-1:0] rr_pick(
      input logic [N_SRC-1:0] v,
      input logic [IW-1:0]    p
   );
      logic [IW-1:0] r;
      logic          found;
      int            j;
      r     = p;
      found = 1'b0;
      for (int k = 1; k <= N_SRC; k++) begin
         j = (int'(p) + k) % N_SRC;
         if (v[j] && !found) begin
            r     = j[IW-1:0];
            found = 1'b1;
         end
      end
      return r;
   endfunction

   // release/rotate decision and next register values
   always_comb begin
      state_n    = IDLE;
      ptr_n      = ptr;
      id_n       = '0;
      grant_n    = '0;
      dwell_n    = '0;
      bcnt_n     = '0;
      en_n       = 1'b0;
      data_n     = '0;
      take       = 1'b0;
      hold       = 1'b0;
      others     = req & ~grant;
      pool       = (state == IDLE) ? req : others;
      pick       = rr_pick(pool, ptr);
      dwell_done = (dwell == DWELL_MAX);
      wrap       = (bcnt == BLINK_MAX);
      if (state == IDLE) begin
         take = |req;
      end else if (!req[active_id]) begin
         take = |others;
      end else if (auto_rotate && dwell_done && |others) begin
         take = 1'b1;
      end else begin
         hold = 1'b1;
      end
      unique case (1'b1)
         take: begin
            state_n = SHOW;
            ptr_n   = pick;
            id_n    = pick;
            grant_n = ONE << pick;
            en_n    = 1'b1;
            data_n  = src_data[32*pick +: 32];
         end
         hold: begin
            state_n = SHOW;
            id_n    = active_id;
            grant_n = grant;
            dwell_n = dwell_done ? dwell : dwell + 1'b1;
            bcnt_n  = wrap ? '0 : bcnt + 1'b1;
            en_n    = blink[active_id] ?
                      (wrap ? ~disp_enable : disp_enable) : 1'b1;
            data_n  = src_data[32*active_id +: 32];
         end
         default: ;
      endcase
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= PTR_RST;
         dwell       <= '0;
         bcnt        <= '0;
         grant       <= '0;
         active_id   <= '0;
         disp_data   <= '0;
         disp_enable <= 1'b0;
      end else begin
         state       <= state_n;
         ptr         <= ptr_n;
         dwell       <= dwell_n;
         bcnt        <= bcnt_n;
         grant       <= grant_n;
         active_id   <= id_n;
         disp_data   <= data_n;
         disp_enable <= en_n;
      end
   end
endmodule

// File: tb/tb_display_mux_ctrl.sv
// tb_display_mux_ctrl: vector table, corner sequences and random
// traffic checked against a cycle-age reference model.
module tb_display_mux_ctrl;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int BH = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   req;
   logic [127:0] src_data;
   logic [3:0]   blink;
   logic         auto_rotate;
   logic [31:0]  disp_data;
   logic         disp_enable;
   logic [3:0]   grant;
   logic [1:0]   active_id;

   int total = 0;
   int bad   = 0;

   int          m_owner;
   int          m_ptr;
   int          m_age;
   logic        m_en;
   logic [31:0] m_data;

   typedef struct {
      logic [3:0]  req;
      logic        ar;
      logic [3:0]  bl;
      int          n;
      logic [3:0]  g;
      logic [1:0]  id;
      logic        en;
      logic [31:0] d;
   } vec_t;

   vec_t tbl [7];
   logic pat [10];

   always #5 clk = ~clk;

   display_mux_ctrl #(
      .N_SRC(N), .DWELL_CYCLES(DW), .BLINK_HALF(BH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .src_data(src_data),
      .blink(blink), .auto_rotate(auto_rotate),
      .disp_data(disp_data), .disp_enable(disp_enable),
      .grant(grant), .active_id(active_id)
   );

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, a, e);
      end
   endtask

   function automatic int rr_pick(input logic [3:0] v);
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (m_ptr + k) % N;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   task automatic m_idle();
      m_owner = -1;
      m_age   = 0;
      m_en    = 1'b0;
      m_data  = '0;
   endtask

   task automatic m_reset();
      m_idle();
      m_ptr = N - 1;
   endtask

   task automatic m_grant(input int i);
      m_owner = i;
      m_ptr   = i;
      m_age   = 0;
      m_en    = 1'b1;
      m_data  = src_data[32*i +: 32];
   endtask

   task automatic m_step();
      logic [3:0] oth;
      if (m_owner < 0) begin
         if (req != 0) m_grant(rr_pick(req));
      end else begin
         oth = req & ~(4'b0001 << m_owner);
         if (!req[m_owner]) begin
            if (oth != 0) m_grant(rr_pick(oth));
            else m_idle();
         end else if (auto_rotate && m_age >= DW - 1 && oth != 0) begin
            m_grant(rr_pick(oth));
         end else begin
            if (blink[m_owner]) begin
               if (m_age % BH == BH - 1) m_en = ~m_en;
            end else begin
               m_en = 1'b1;
            end
            m_age++;
            m_data = src_data[32*m_owner +: 32];
         end
      end
   endtask

   task automatic chk_model(input string tag);
      logic [31:0] eg, ei;
      eg = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
      ei = (m_owner < 0) ? 32'd0 : 32'(m_owner);
      chk({tag, " grant"}, 32'(grant), eg);
      chk({tag, " id"}, 32'(active_id), ei);
      chk({tag, " data"}, disp_data, m_data);
      chk({tag, " en"}, 32'(disp_enable), 32'(m_en));
      chk({tag, " onehot"}, 32'($onehot0(grant)), 32'd1);
   endtask

   task automatic step();
      m_step();
      @(posedge clk);
      #1;
      chk_model("mdl");
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_model("rst");
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n       = 1'b0;
      req         = '0;
      blink       = '0;
      auto_rotate = 1'b1;
      src_data    = {32'hBEEF0003, 32'hCAFE0002,
                     32'h12345678, 32'h0BAD0000};

      tbl[0] = '{4'b0000, 1'b1, 4'b0, 20, 4'b0000, 2'd0, 1'b0, 32'h0};
      tbl[1] = '{4'b0110, 1'b1, 4'b0, 1, 4'b0010, 2'd1, 1'b1,
                 32'h12345678};
      tbl[2] = '{4'b0110, 1'b1, 4'b0, 7, 4'b0010, 2'd1, 1'b1,
                 32'h12345678};
      tbl[3] = '{4'b0110, 1'b1, 4'b0, 1, 4'b0100, 2'd2, 1'b1,
                 32'hCAFE0002};
      tbl[4] = '{4'b0110, 1'b1, 4'b0, 7, 4'b0100, 2'd2, 1'b1,
                 32'hCAFE0002};
      tbl[5] = '{4'b0110, 1'b1, 4'b0, 1, 4'b0010, 2'd1, 1'b1,
                 32'h12345678};
      tbl[6] = '{4'b0000, 1'b1, 4'b0, 1, 4'b0000, 2'd0, 1'b0, 32'h0};
      pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
              1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

      do_reset();

      for (int r = 0; r < 7; r++) begin
         req         = tbl[r].req;
         auto_rotate = tbl[r].ar;
         blink       = tbl[r].bl;
         for (int c = 0; c < tbl[r].n; c++) step();
         chk($sformatf("tbl%0d grant", r), 32'(grant), 32'(tbl[r].g));
         chk($sformatf("tbl%0d id", r), 32'(active_id), 32'(tbl[r].id));
         chk($sformatf("tbl%0d en", r), 32'(disp_enable), 32'(tbl[r].en));
         chk($sformatf("tbl%0d data", r), disp_data, tbl[r].d);
      end

      do_reset();
      auto_rotate = 1'b0;
      req = 4'b1001;
      step();
      chk("hold first", 32'(grant), 32'h1);
      repeat (49) step();
      chk("hold 50", 32'(grant), 32'h1);
      req = 4'b1000;
      step();
      chk("handoff", 32'(grant), 32'h8);
      req = 4'b0000;
      step();
      chk("idle grant", 32'(grant), 32'h0);
      chk("idle en", 32'(disp_enable), 32'h0);

      req = 4'b0100;
      step();
      chk("src2 grant", 32'(grant), 32'h4);
      repeat (3) step();
      req = 4'b0000;
      step();
      chk("early rel", 32'(grant), 32'h0);
      req = 4'b0001;
      step();
      chk("after early", 32'(grant), 32'h1);

      req = 4'b0000;
      step();
      blink = 4'b0001;
      req   = 4'b0001;
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("blink%0d", i), 32'(disp_enable), 32'(pat[i]));
      end
      blink = 4'b0000;
      step();
      chk("blink off", 32'(disp_enable), 32'h1);

      do_reset();
      req = 4'b0100;
      repeat (3) step();
      chk("pre rst", 32'(grant), 32'h4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async grant", 32'(grant), 32'h0);
      chk("async en", 32'(disp_enable), 32'h0);
      chk("async data", disp_data, 32'h0);
      chk("async id", 32'(active_id), 32'h0);
      m_reset();
      req = 4'b0101;
      #1;
      rst_n = 1'b1;
      step();
      chk("post rst", 32'(grant), 32'h1);

      auto_rotate = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 9) < 3) req = 4'($urandom);
         if ($urandom_range(0, 19) == 0) blink = 4'($urandom);
         if ($urandom_range(0, 49) == 0) auto_rotate = ~auto_rotate;
         src_data = {$urandom, $urandom, $urandom, $urandom};
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
